pmpseqchecker: RTL and testbench

PMPSEQCHECKER -- requirements
Module: pmpseqchecker

---
 rtl/pmpseqchecker_pkg.sv | 18 +
 rtl/pmpseqchecker_adrdec.sv | 68 ++++++
 rtl/pmpseqchecker.sv | 202 ++++++++++++++++++++
 tb/tb_pmpseqchecker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmpseqchecker_pkg.sv
// pmppkg
// Shared types and constants for the sequential PMP checker.
// Holds the walk FSM state type and the PMP address-matching mode encodings
// taken from the A field (cfg bits 4:3) of each PMP configuration byte.
package pmppkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WALK = 2'b01,
      RESP = 2'b10
   } walkState_t;

   localparam logic [1:0] OFF   = 2'b00;
   localparam logic [1:0] TOR   = 2'b01;
   localparam logic [1:0] NA4   = 2'b10;
   localparam logic [1:0] NAPOT = 2'b11;

endpackage

// File: rtl/pmpseqchecker_adrdec.sv
// pmpadrdec
// Address decoder for a single PMP entry. The checker time-multiplexes one
// instance of this block across all entries, one entry per clock.
// Ports:
//   firstAddr_i  first byte address of the access
//   lastAddr_i   last byte address of the access
//   addrMode_i   A field of the selected entry (OFF/TOR/NA4/NAPOT)
//   pmpAdr_i     pmpaddr of the selected entry (address bits PA_BITS-1:2)
//   pageIn_i     "address >= previous entry's pmpaddr" carried from the walk
//   pageOut_o    "address >= this entry's pmpaddr", feeds the next entry's TOR
//   match_o      the whole access lies inside this entry's region
module pmpadrdec
   import pmppkg::*;
#(
   parameter int PA_BITS = 34
) (
   input  logic [PA_BITS-1:0] firstAddr_i,
   input  logic [PA_BITS-1:0] lastAddr_i,
   input  logic [1:0]         addrMode_i,
   input  logic [PA_BITS-3:0] pmpAdr_i,
   input  logic               pageIn_i,
   output logic               pageOut_o,
   output logic               match_o
);

   logic [PA_BITS-1:0] regionBound;
   logic [PA_BITS-3:0] careMask;
   logic               torMatch;
   logic               na4Match;
   logic               napotMatch;

   assign regionBound = {pmpAdr_i, 2'b00};

   // The lower bound of a TOR region is the previous entry's pmpaddr, so the
   // comparison against this entry's pmpaddr is exported for the next step
   // regardless of this entry's mode; OFF entries still advance the chain.
   assign pageOut_o = (firstAddr_i >= regionBound);
   assign torMatch  = pageIn_i & (lastAddr_i < regionBound);

   // NAPOT encodes region size by trailing ones in pmpaddr: every word-address
   // bit at or below the first zero is a don't-care, everything above must
   // equal pmpaddr.
   always_comb begin
      logic onesBelow;
      careMask  = '0;
      onesBelow = 1'b1;
      for (int i = 0; i < PA_BITS-2; i++) begin
         careMask[i] = ~onesBelow;
         onesBelow   = onesBelow & pmpAdr_i[i];
      end
   end

   assign napotMatch = ((((firstAddr_i[PA_BITS-1:2] ^ pmpAdr_i) & careMask) == '0) &&
                        (((lastAddr_i[PA_BITS-1:2]  ^ pmpAdr_i) & careMask) == '0));
   assign na4Match   = (firstAddr_i[PA_BITS-1:2] == pmpAdr_i) &&
                       (lastAddr_i[PA_BITS-1:2]  == pmpAdr_i);

   // Select the match result for the entry's addressing mode; OFF never matches.
   always_comb begin
      case (addrMode_i)
         TOR:     match_o = torMatch;
         NA4:     match_o = na4Match;
         NAPOT:   match_o = napotMatch;
         default: match_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pmpseqchecker.sv
// pmpseqchecker
// Sequential PMP checker: walks the PMP entries one per clock using a single
// shared address decoder and reports the first matching entry and whether the
// access faults.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   Flush                       abandon any walk or pending response
//   ReqValid/ReqReady           request handshake
//   PhysicalAddress, Size       access address and log2 byte count
//   Read/Write/ExecuteAccess    one-hot access type
//   EffectivePrivilegeMode      11=M, 01=S, 00=U
//   PMPCfg, PMPAdr              live PMP CSR contents (held stable while Busy)
//   Busy                        walk or response outstanding
//   RespValid/RespReady         response handshake
//   PMPFault, MatchIdx          result, valid with RespValid
module pmpseqchecker
   import pmppkg::*;
#(
   parameter int PA_BITS     = 34,
   parameter int PMP_ENTRIES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Flush,
   input  logic               ReqValid,
   output logic               ReqReady,
   input  logic [PA_BITS-1:0] PhysicalAddress,
   input  logic [1:0]         Size,
   input  logic               ReadAccess,
   input  logic               WriteAccess,
   input  logic               ExecuteAccess,
   input  logic [1:0]         EffectivePrivilegeMode,
   input  logic [7:0]         PMPCfg [PMP_ENTRIES-1:0],
   input  logic [PA_BITS-3:0] PMPAdr [PMP_ENTRIES-1:0],
   output logic               Busy,
   output logic               RespValid,
   input  logic               RespReady,
   output logic               PMPFault,
   output logic [5:0]         MatchIdx
);

   walkState_t         stateQ, stateD;
   logic [5:0]         idxQ, idxD;
   logic               pAgePrevQ, pAgePrevD;
   logic [PA_BITS-1:0] addrQ, addrD;
   logic [1:0]         sizeQ, sizeD;
   logic               readQ, readD, writeQ, writeD, execQ, execD;
   logic [1:0]         privQ, privD;
   logic               hitQ, hitD;
   logic               lockQ, lockD, xQ, xD, wQ, wD, rQ, rD;
   logic [5:0]         matchIdxQ, matchIdxD;

   logic [7:0]         cfgSel;
   logic [PA_BITS-3:0] adrSel;
   logic [PA_BITS-1:0] lastAddr;
   logic               pAgeOut;
   logic               entryMatch;
   logic               lastEntry;
   logic               accessOk;
   logic               faultRaw;

   // Pick the current entry's CSRs. A compare loop keeps the index width
   // independent of PMP_ENTRIES and yields zero for any out-of-range index.
   always_comb begin
      cfgSel = '0;
      adrSel = '0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         if (idxQ == 6'(i)) begin
            cfgSel = PMPCfg[i];
            adrSel = PMPAdr[i];
         end
      end
   end

   assign lastAddr  = addrQ + ((PA_BITS'(1) << sizeQ) - PA_BITS'(1));
   assign lastEntry = (idxQ == 6'(PMP_ENTRIES-1));

   pmpadrdec #(
      .PA_BITS(PA_BITS)
   ) uAdrDec (
      .firstAddr_i(addrQ),
      .lastAddr_i (lastAddr),
      .addrMode_i (cfgSel[4:3]),
      .pmpAdr_i   (adrSel),
      .pageIn_i   (pAgePrevQ),
      .pageOut_o  (pAgeOut),
      .match_o    (entryMatch)
   );

   // Next-state logic for the walk. Flush wins over a match or a consumed
   // response; a request is only taken from IDLE, so a response handshake
   // never overlaps a new accept.
   always_comb begin
      stateD    = stateQ;
      idxD      = idxQ;
      pAgePrevD = pAgePrevQ;
      addrD     = addrQ;
      sizeD     = sizeQ;
      readD     = readQ;
      writeD    = writeQ;
      execD     = execQ;
      privD     = privQ;
      hitD      = hitQ;
      lockD     = lockQ;
      xD        = xQ;
      wD        = wQ;
      rD        = rQ;
      matchIdxD = matchIdxQ;
      case (stateQ)
         IDLE: begin
            if (ReqValid && ReqReady) begin
               addrD     = PhysicalAddress;
               sizeD     = Size;
               readD     = ReadAccess;
               writeD    = WriteAccess;
               execD     = ExecuteAccess;
               privD     = EffectivePrivilegeMode;
               idxD      = '0;
               pAgePrevD = 1'b1;
               stateD    = WALK;
            end
         end
         WALK: begin
            if (Flush) begin
               stateD = IDLE;
            end else if (entryMatch) begin
               lockD     = cfgSel[7];
               xD        = cfgSel[2];
               wD        = cfgSel[1];
               rD        = cfgSel[0];
               matchIdxD = idxQ;
               hitD      = 1'b1;
               stateD    = RESP;
            end else if (lastEntry) begin
               hitD      = 1'b0;
               matchIdxD = '0;
               stateD    = RESP;
            end else begin
               idxD      = idxQ + 6'd1;
               pAgePrevD = pAgeOut;
            end
         end
         RESP: begin
            if (Flush || RespReady) begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // State and request registers. Reset clears everything the result depends
   // on so outputs read zero straight out of reset, even mid-walk.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= IDLE;
         idxQ      <= '0;
         pAgePrevQ <= 1'b1;
         addrQ     <= '0;
         sizeQ     <= '0;
         readQ     <= 1'b0;
         writeQ    <= 1'b0;
         execQ     <= 1'b0;
         privQ     <= '0;
         hitQ      <= 1'b0;
         lockQ     <= 1'b0;
         xQ        <= 1'b0;
         wQ        <= 1'b0;
         rQ        <= 1'b0;
         matchIdxQ <= '0;
      end else begin
         stateQ    <= stateD;
         idxQ      <= idxD;
         pAgePrevQ <= pAgePrevD;
         addrQ     <= addrD;
         sizeQ     <= sizeD;
         readQ     <= readD;
         writeQ    <= writeD;
         execQ     <= execD;
         privQ     <= privD;
         hitQ      <= hitD;
         lockQ     <= lockD;
         xQ        <= xD;
         wQ        <= wD;
         rQ        <= rD;
         matchIdxQ <= matchIdxD;
      end
   end

   // The fault is a function of registers only, so it stays stable for as long
   // as the response is held. M-mode is only restricted by locked entries and
   // is allowed everything when no entry matches.
   assign accessOk = (readQ & rQ) | (writeQ & wQ) | (execQ & xQ);
   assign faultRaw = hitQ ? (((privQ != 2'b11) | lockQ) & ~accessOk) : (privQ != 2'b11);

   assign ReqReady  = (stateQ == IDLE) & ~Flush;
   assign Busy      = (stateQ != IDLE);
   assign RespValid = (stateQ == RESP);
   assign PMPFault  = RespValid & faultRaw;
   assign MatchIdx  = matchIdxQ;

endmodule

// File: tb/tb_pmpseqchecker.sv
// tb_pmpseqchecker
// Scoreboard bench for pmpseqchecker: directed requests push their expected
// fault, index and latency into a queue; an independent monitor pops and
// compares each response as it appears.
module tb_pmpseqchecker;

   localparam int PA_BITS     = 34;
   localparam int PMP_ENTRIES = 16;

   typedef struct {
      logic       fault;
      logic [5:0] idx;
      int         lat;
      int         acceptCycle;
   } expResp_t;

   logic               clk;
   logic               reset;
   logic               Flush;
   logic               ReqValid;
   logic               ReqReady;
   logic [PA_BITS-1:0] PhysicalAddress;
   logic [1:0]         Size;
   logic               ReadAccess;
   logic               WriteAccess;
   logic               ExecuteAccess;
   logic [1:0]         EffectivePrivilegeMode;
   logic [7:0]         pmpCfg [PMP_ENTRIES-1:0];
   logic [PA_BITS-3:0] pmpAdr [PMP_ENTRIES-1:0];
   logic               Busy;
   logic               RespValid;
   logic               RespReady;
   logic               PMPFault;
   logic [5:0]         MatchIdx;

   expResp_t scoreboard[$];
   int       cycleCnt   = 0;
   int       checkCount = 0;
   int       passCount  = 0;
   int       respCount  = 0;
   bit       respSeen   = 0;

   pmpseqchecker #(
      .PA_BITS    (PA_BITS),
      .PMP_ENTRIES(PMP_ENTRIES)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .Flush                 (Flush),
      .ReqValid              (ReqValid),
      .ReqReady              (ReqReady),
      .PhysicalAddress       (PhysicalAddress),
      .Size                  (Size),
      .ReadAccess            (ReadAccess),
      .WriteAccess           (WriteAccess),
      .ExecuteAccess         (ExecuteAccess),
      .EffectivePrivilegeMode(EffectivePrivilegeMode),
      .PMPCfg                (pmpCfg),
      .PMPAdr                (pmpAdr),
      .Busy                  (Busy),
      .RespValid             (RespValid),
      .RespReady             (RespReady),
      .PMPFault              (PMPFault),
      .MatchIdx              (MatchIdx)
   );

   // Free-running clock and a cycle counter used to measure response latency.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Single place where a comparison is counted and reported.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clearPmp();
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         pmpCfg[i] = 8'h00;
         pmpAdr[i] = '0;
      end
   endtask

   task automatic waitIdle();
      int guard = 0;
      @(negedge clk);
      while (Busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (Busy) checkOutput("idleTimeout", 64'(Busy), 64'd0);
   endtask

   // Issue one request from a negedge, hold it across the accepting edge and
   // queue the expected response unless the caller intends to abort it.
   task automatic applyStimulus(input logic [PA_BITS-1:0] addr, input logic [1:0] size,
                                input logic r, input logic w, input logic x, input logic [1:0] priv,
                                input logic expFault, input logic [5:0] expIdx, input int expLat,
                                input bit expectResp, input bit waitDone);
      int guard = 0;
      expResp_t e;
      @(negedge clk);
      while (!ReqReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!ReqReady) checkOutput("reqReadyTimeout", 64'(ReqReady), 64'd1);
      PhysicalAddress        = addr;
      Size                   = size;
      ReadAccess             = r;
      WriteAccess            = w;
      ExecuteAccess          = x;
      EffectivePrivilegeMode = priv;
      ReqValid               = 1'b1;
      @(posedge clk);
      #1;
      ReqValid = 1'b0;
      if (expectResp) begin
         e.fault       = expFault;
         e.idx         = expIdx;
         e.lat         = expLat;
         e.acceptCycle = cycleCnt;
         scoreboard.push_back(e);
      end
      if (waitDone) waitIdle();
   endtask

   // Monitor: compares each new response against the oldest expectation.
   initial begin
      expResp_t e;
      forever begin
         @(negedge clk);
         if (RespValid) begin
            if (!respSeen) begin
               respSeen = 1'b1;
               respCount++;
               if (scoreboard.size() == 0) begin
                  checkOutput("unexpectedResp", 64'd1, 64'd0);
               end else begin
                  e = scoreboard.pop_front();
                  checkOutput("respFault", 64'(PMPFault), 64'(e.fault));
                  checkOutput("respIdx", 64'(MatchIdx), 64'(e.idx));
                  checkOutput("respLatency", 64'(cycleCnt - e.acceptCycle), 64'(e.lat));
               end
            end
         end else begin
            respSeen = 1'b0;
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      int guard;
      int respBefore;
      reset                  = 1'b1;
      Flush                  = 1'b0;
      ReqValid               = 1'b0;
      RespReady              = 1'b1;
      PhysicalAddress        = '0;
      Size                   = '0;
      ReadAccess             = 1'b0;
      WriteAccess            = 1'b0;
      ExecuteAccess          = 1'b0;
      EffectivePrivilegeMode = 2'b11;
      clearPmp();
      repeat (3) @(negedge clk);
      checkOutput("resetBusy", 64'(Busy), 64'd0);
      checkOutput("resetRespValid", 64'(RespValid), 64'd0);
      checkOutput("resetReqReady", 64'(ReqReady), 64'd1);
      checkOutput("resetFault", 64'(PMPFault), 64'd0);
      checkOutput("resetMatchIdx", 64'(MatchIdx), 64'd0);
      reset = 1'b0;

      // Entry 0 TOR up to 0x1000, read-only.
      clearPmp();
      pmpAdr[0] = 32'h400; pmpCfg[0] = 8'h09;
      applyStimulus(34'h800, 2'd0, 1, 0, 0, 2'b01, 1'b0, 6'd0, 1, 1, 1);
      applyStimulus(34'h800, 2'd0, 0, 1, 0, 2'b01, 1'b1, 6'd0, 1, 1, 1);
      applyStimulus(34'hFFC, 2'd2, 1, 0, 0, 2'b01, 1'b0, 6'd0, 1, 1, 1);
      applyStimulus(34'hFFE, 2'd2, 1, 0, 0, 2'b01, 1'b1, 6'd0, 16, 1, 1);
      applyStimulus(34'h1000, 2'd0, 1, 0, 0, 2'b01, 1'b1, 6'd0, 16, 1, 1);

      // Entry 3 NAPOT covering 0x000-0xFFF with RWX, entries 0-2 OFF.
      clearPmp();
      pmpAdr[3] = 32'h1FF; pmpCfg[3] = 8'h1F;
      applyStimulus(34'h400, 2'd0, 0, 0, 1, 2'b00, 1'b0, 6'd3, 4, 1, 1);
      applyStimulus(34'hFFF, 2'd0, 0, 0, 1, 2'b00, 1'b0, 6'd3, 4, 1, 1);
      applyStimulus(34'h1000, 2'd0, 0, 0, 1, 2'b00, 1'b1, 6'd0, 16, 1, 1);

      // All entries OFF: only M-mode is allowed.
      clearPmp();
      applyStimulus(34'h0, 2'd0, 1, 0, 0, 2'b11, 1'b0, 6'd0, 16, 1, 1);
      applyStimulus(34'h0, 2'd0, 1, 0, 0, 2'b01, 1'b1, 6'd0, 16, 1, 1);

      // Locked NA4 at 0x400 (R only) followed by TOR 0x400-0x7FF (RWX).
      clearPmp();
      pmpAdr[0] = 32'h100; pmpCfg[0] = 8'h91;
      pmpAdr[1] = 32'h200; pmpCfg[1] = 8'h0F;
      applyStimulus(34'h400, 2'd0, 0, 1, 0, 2'b11, 1'b1, 6'd0, 1, 1, 1);
      applyStimulus(34'h400, 2'd0, 1, 0, 0, 2'b11, 1'b0, 6'd0, 1, 1, 1);
      applyStimulus(34'h400, 2'd0, 1, 0, 0, 2'b00, 1'b0, 6'd0, 1, 1, 1);
      applyStimulus(34'h404, 2'd0, 0, 1, 0, 2'b01, 1'b0, 6'd1, 2, 1, 1);
      applyStimulus(34'h3FC, 2'd0, 0, 1, 0, 2'b01, 1'b1, 6'd0, 16, 1, 1);

      // Backpressure: response held for 5 cycles with a faulting NAPOT hit.
      clearPmp();
      pmpAdr[3] = 32'h1FF; pmpCfg[3] = 8'h1B;
      RespReady = 1'b0;
      applyStimulus(34'h400, 2'd0, 0, 0, 1, 2'b00, 1'b1, 6'd3, 4, 1, 0);
      guard = 0;
      @(negedge clk);
      while (!RespValid && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("holdRespArrived", 64'(RespValid), 64'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("holdRespValid", 64'(RespValid), 64'd1);
         checkOutput("holdFault", 64'(PMPFault), 64'd1);
         checkOutput("holdIdx", 64'(MatchIdx), 64'd3);
         checkOutput("holdReqReady", 64'(ReqReady), 64'd0);
      end
      RespReady = 1'b1;
      #1;
      checkOutput("releaseReqReadySame", 64'(ReqReady), 64'd0);
      @(negedge clk);
      checkOutput("releaseReqReadyNext", 64'(ReqReady), 64'd1);
      checkOutput("releaseRespValid", 64'(RespValid), 64'd0);

      // Flush on walk cycle 2 of a 16-entry miss.
      clearPmp();
      respBefore = respCount;
      applyStimulus(34'h0, 2'd0, 1, 0, 0, 2'b01, 1'b0, 6'd0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      Flush = 1'b1;
      @(posedge clk);
      #1;
      Flush = 1'b0;
      @(negedge clk);
      checkOutput("flushBusy", 64'(Busy), 64'd0);
      checkOutput("flushRespValid", 64'(RespValid), 64'd0);
      repeat (20) @(negedge clk);
      checkOutput("flushNoResp", 64'(respCount - respBefore), 64'd0);

      // Reset during a walk; MatchIdx still holds 3 from the held response.
      respBefore = respCount;
      applyStimulus(34'h0, 2'd0, 1, 0, 0, 2'b01, 1'b0, 6'd0, 0, 0, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      Flush = 1'b1;
      @(negedge clk);
      checkOutput("midResetBusy", 64'(Busy), 64'd0);
      checkOutput("midResetRespValid", 64'(RespValid), 64'd0);
      checkOutput("midResetFault", 64'(PMPFault), 64'd0);
      checkOutput("midResetIdx", 64'(MatchIdx), 64'd0);
      reset = 1'b0;
      Flush = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("midResetNoResp", 64'(respCount - respBefore), 64'd0);

      // Normal operation after reset.
      clearPmp();
      pmpAdr[0] = 32'h400; pmpCfg[0] = 8'h09;
      applyStimulus(34'h10, 2'd1, 1, 0, 0, 2'b00, 1'b0, 6'd0, 1, 1, 1);

      repeat (5) @(negedge clk);
      checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
